// File: rtl/addsub_seq_pkg.sv
// Shared ALU datapath definitions: sequencer state encoding and slice-count helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned slice_count(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for the sequential adder/subtractor.
interface addsub_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/addsub_seq_ripple_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the caller can derive signed overflow on the top slice.
module ripple_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic c;

  always_comb begin
    s    = '0;
    c    = ci;
    cmsb = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry rippled
// through a register, valid/ready on both sides, registered flags.
module addsub_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  addsub_seq_if.slave bus
);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $fatal(1, "addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  localparam int unsigned N  = slice_count(WIDTH, CHUNK);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q, ovf_q, zero_q;
  logic             load, step, last;

  logic [CHUNK-1:0] slice_s;
  logic             slice_co, slice_cmsb;

  ripple_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .ci   (c_q),
    .s    (slice_s),
    .co   (slice_co),
    .cmsb (slice_cmsb)
  );

  assign last  = (cnt_q == CW'(N - 1));
  // Slices are produced LSB first, so each one enters at the top and the
  // result settles into place after N shifts.
  assign res_d = (res_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        a_q   <= bus.a;
        b_q   <= bus.sub ? ~bus.b : bus.b;
        c_q   <= bus.cin ^ bus.sub;
        cnt_q <= '0;
      end else if (step) begin
        a_q   <= a_q >> CHUNK;
        b_q   <= b_q >> CHUNK;
        c_q   <= slice_co;
        res_q <= res_d;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          cout_q <= slice_co;
          ovf_q  <= slice_cmsb ^ slice_co;
          zero_q <= (res_d == '0);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = res_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq at CHUNK 4, 16 and 1 (WIDTH 16).
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] ta = '0, tbv = '0;
  logic        tsub = 1'b0, tcin = 1'b0;
  logic [2:0]  iv = '0, ordy = '0;

  logic        ir [3];
  logic        ov [3];
  logic [15:0] sm [3];
  logic        co [3];
  logic        of [3];
  logic        zr [3];

  int nvec = 0;
  int nerr = 0;

  addsub_seq_if #(.WIDTH(16)) bus4 ();
  addsub_seq_if #(.WIDTH(16)) bus16 ();
  addsub_seq_if #(.WIDTH(16)) bus1 ();

  addsub_seq #(.WIDTH(16), .CHUNK(4))  u4  (.clk(clk), .rst(rst), .bus(bus4));
  addsub_seq #(.WIDTH(16), .CHUNK(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));
  addsub_seq #(.WIDTH(16), .CHUNK(1))  u1  (.clk(clk), .rst(rst), .bus(bus1));

  assign bus4.a = ta;   assign bus4.b = tbv;   assign bus4.sub = tsub;   assign bus4.cin = tcin;
  assign bus16.a = ta;  assign bus16.b = tbv;  assign bus16.sub = tsub;  assign bus16.cin = tcin;
  assign bus1.a = ta;   assign bus1.b = tbv;   assign bus1.sub = tsub;   assign bus1.cin = tcin;
  assign bus4.in_valid  = iv[0];  assign bus4.out_ready  = ordy[0];
  assign bus16.in_valid = iv[1];  assign bus16.out_ready = ordy[1];
  assign bus1.in_valid  = iv[2];  assign bus1.out_ready  = ordy[2];

  assign ir[0] = bus4.in_ready;  assign ov[0] = bus4.out_valid;  assign sm[0] = bus4.sum;
  assign co[0] = bus4.cout;      assign of[0] = bus4.overflow;   assign zr[0] = bus4.zero;
  assign ir[1] = bus16.in_ready; assign ov[1] = bus16.out_valid; assign sm[1] = bus16.sum;
  assign co[1] = bus16.cout;     assign of[1] = bus16.overflow;  assign zr[1] = bus16.zero;
  assign ir[2] = bus1.in_ready;  assign ov[2] = bus1.out_valid;  assign sm[2] = bus1.sum;
  assign co[2] = bus1.cout;      assign of[2] = bus1.overflow;   assign zr[2] = bus1.zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive operands and hold in_valid until the DUT accepts; returns #1 after the accepting edge.
  task automatic start_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c);
    logic ok;
    logic taken;
    taken = 1'b0;
    ta = a; tbv = b; tsub = s; tcin = c;
    iv[d] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok = ir[d];
      @(posedge clk);
      #1;
      if (ok) begin
        taken = 1'b1;
        break;
      end
    end
    iv[d] = 1'b0;
    chk("accept", {31'd0, taken}, 32'd1);
  endtask

  task automatic wait_done(input int d, input logic [15:0] es, input logic ec, input logic eo,
                           input logic ez, input int lat, input logic release_it);
    int  cnt;
    logic seen;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ov[d]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("out_valid", {31'd0, seen}, 32'd1);
    if (seen) begin
      chk("latency",  cnt, lat);
      chk("sum",      {16'd0, sm[d]}, {16'd0, es});
      chk("cout",     {31'd0, co[d]}, {31'd0, ec});
      chk("overflow", {31'd0, of[d]}, {31'd0, eo});
      chk("zero",     {31'd0, zr[d]}, {31'd0, ez});
      chk("in_ready_done", {31'd0, ir[d]}, 32'd0);
    end
    if (release_it) begin
      ordy[d] = 1'b1;
      @(posedge clk);
      #1;
      ordy[d] = 1'b0;
      chk("out_valid_fall", {31'd0, ov[d]}, 32'd0);
      chk("in_ready_rise",  {31'd0, ir[d]}, 32'd1);
    end
  endtask

  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez, input int lat);
    start_op(d, a, b, s, c);
    wait_done(d, es, ec, eo, ez, lat, 1'b1);
  endtask

  // Reference: {cout, overflow, zero, sum}; overflow from operand/result signs.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    logic [15:0] x;
    logic [16:0] full;
    logic        o;
    x    = s ? ~b : b;
    full = {1'b0, a} + {1'b0, x} + 17'(c ^ s);
    o    = (a[15] == x[15]) && (full[15] != a[15]);
    return {full[16], o, (full[15:0] == 16'd0), full[15:0]};
  endfunction

  initial begin
    logic [15:0] ra, rb;
    logic        rs, rc;
    logic [18:0] m;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, ir[0]}, 32'd0);
    chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_sum",       {16'd0, sm[0]}, 32'd0);
    chk("rst_flags",     {29'd0, co[0], of[0], zr[0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, ir[0]}, 32'd1);

    // CHUNK 4 directed vectors
    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 4);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 4);
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4);
    run_op(0, 16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 4);
    run_op(0, 16'h00FF, 16'h0100, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 4);
    run_op(0, 16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 4);
    run_op(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4);

    // Backpressure with competing operands
    start_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(0, 16'h3333, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    ta = 16'hAAAA; tbv = 16'h5555; iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, ov[0]}, 32'd1);
      chk("bp_sum",       {16'd0, sm[0]}, 32'h3333);
      chk("bp_in_ready",  {31'd0, ir[0]}, 32'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp_release_valid", {31'd0, ov[0]}, 32'd0);
    chk("bp_release_ready", {31'd0, ir[0]}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_not_taken", {31'd0, ov[0]}, 32'd0);

    // Reset after two RUN cycles
    start_op(0, 16'h5555, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("abort_sum",       {16'd0, sm[0]}, 32'd0);
    chk("abort_in_ready",  {31'd0, ir[0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_recover_ready", {31'd0, ir[0]}, 32'd1);
    run_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 4);

    // CHUNK 16 and CHUNK 1
    run_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1);
    run_op(2, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 16);
    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      m  = model(ra, rb, rs, rc);
      run_op(1, ra, rb, rs, rc, m[15:0], m[18], m[17], m[16], 1);
      run_op(2, ra, rb, rs, rc, m[15:0], m[18], m[17], m[16], 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
